// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation PE array: reference-shift
// encodings, default geometry and the pixel type.
package me_pkg;

    typedef enum logic [1:0] {
        REF_UP1 = 2'd0,
        REF_DN1 = 2'd1,
        REF_UPS = 2'd2,
        REF_DNS = 2'd3
    } ref_mode_e;

    localparam int PIXEL_DEF = 8;
    localparam int X_DEF     = 32;
    localparam int Y_DEF     = 32;
    localparam int STEP_DEF  = 8;

    typedef logic [PIXEL_DEF-1:0] pixel_t;

endpackage

// File: rtl/me_cur_loader.sv
// Current-block loader: assembles beats into a staging row and tells the
// array when a full row is ready to enter the latched bank.
module me_cur_loader
    import me_pkg::*;
#(
    parameter int PIXEL  = PIXEL_DEF,
    parameter int X      = X_DEF,
    parameter int Y      = Y_DEF,
    parameter int CPC    = 2,
    parameter int NUM_CB = 4,
    localparam int BW    = (NUM_CB > 1) ? $clog2(NUM_CB) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CPC*PIXEL-1:0]  cur_pix_in,
    input  logic                  cur_valid,
    input  logic [BW-1:0]         cur_bank,
    input  logic                  cur_clr,
    output logic [NUM_CB-1:0]     cb_loaded,
    output logic                  cur_busy,
    output logic                  commit,
    output logic [BW-1:0]         commit_bank,
    output logic [X*PIXEL-1:0]    commit_row
);

    localparam int BEATS = X / CPC;
    localparam int BEATW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROWW  = $clog2(Y);
    localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(BEATS - 1);
    localparam logic [ROWW-1:0]  LAST_ROW  = ROWW'(Y - 1);

    logic [BEATW-1:0]            beat_q, beat_d;
    logic [ROWW-1:0]             row_q, row_d;
    logic [BW-1:0]               bank_q, bank_d;
    logic                        busy_q, busy_d;
    logic [NUM_CB-1:0]           loaded_q, loaded_d;
    logic [X-1:0][PIXEL-1:0]     stage_q, stage_d;
    logic [CPC-1:0][PIXEL-1:0]   pix;

    assign pix = cur_pix_in;

    always_comb begin
        beat_d   = beat_q;
        row_d    = row_q;
        bank_d   = bank_q;
        busy_d   = busy_q;
        loaded_d = loaded_q;
        stage_d  = stage_q;
        commit   = 1'b0;
        if (cur_clr) begin
            beat_d = '0;
            row_d  = '0;
            busy_d = 1'b0;
        end else if (cur_valid) begin
            // Both counters at zero marks the first beat of a new block.
            if (beat_q == '0 && row_q == '0) begin
                bank_d           = cur_bank;
                loaded_d[cur_bank] = 1'b0;
                busy_d           = 1'b1;
            end
            for (int c = 0; c < X; c++) begin
                if (c / CPC == int'(beat_q)) begin
                    stage_d[c] = pix[c % CPC];
                end
            end
            if (beat_q == LAST_BEAT) begin
                beat_d = '0;
                commit = 1'b1;
                if (row_q == LAST_ROW) begin
                    row_d            = '0;
                    busy_d           = 1'b0;
                    loaded_d[bank_d] = 1'b1;
                end else begin
                    row_d = row_q + ROWW'(1);
                end
            end else begin
                beat_d = beat_q + BEATW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q   <= '0;
            row_q    <= '0;
            bank_q   <= '0;
            busy_q   <= 1'b0;
            loaded_q <= '0;
            stage_q  <= '0;
        end else begin
            beat_q   <= beat_d;
            row_q    <= row_d;
            bank_q   <= bank_d;
            busy_q   <= busy_d;
            loaded_q <= loaded_d;
            stage_q  <= stage_d;
        end
    end

    assign cb_loaded   = loaded_q;
    assign cur_busy    = busy_q;
    assign commit_bank = bank_d;
    assign commit_row  = stage_d;

endmodule

// File: rtl/me_pe_array_p.sv
// PE array for motion estimation: shiftable reference plane, banked current
// blocks and registered absolute differences. ME_ROW_SAD_EN adds per-row sums.
module me_pe_array_p
    import me_pkg::*;
#(
    parameter int PIXEL  = PIXEL_DEF,
    parameter int X      = X_DEF,
    parameter int Y      = Y_DEF,
    parameter int STEP   = STEP_DEF,
    parameter int CPC    = 2,
    parameter int NUM_CB = 4,
    localparam int BW    = (NUM_CB > 1) ? $clog2(NUM_CB) : 1,
    localparam int SW    = PIXEL + $clog2(X)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CPC*PIXEL-1:0]       cur_pix_in,
    input  logic                       cur_valid,
    input  logic [BW-1:0]              cur_bank,
    input  logic                       cur_clr,
    output logic [NUM_CB-1:0]          cb_loaded,
    output logic                       cur_busy,
    input  logic                       ref_shift,
    input  logic [1:0]                 ref_mode,
    input  logic [X*PIXEL-1:0]         ref_row_bot,
    input  logic [X*PIXEL-1:0]         ref_row_top,
    input  logic [STEP*X*PIXEL-1:0]    ref_rows_bot,
    input  logic [STEP*X*PIXEL-1:0]    ref_rows_top,
    input  logic                       abs_en,
    input  logic [BW-1:0]              abs_bank,
    output logic [X*Y*PIXEL-1:0]       abs_out,
    output logic                       abs_valid
`ifdef ME_ROW_SAD_EN
    ,
    output logic [Y*SW-1:0]            row_sad,
    output logic                       row_sad_valid
`endif
);

    typedef logic [Y-1:0][X-1:0][PIXEL-1:0] plane_t;

    plane_t                              ref_q, ref_d;
    plane_t                              abs_q, abs_d;
    plane_t                              cur_sel;
    logic [NUM_CB-1:0][Y-1:0][X-1:0][PIXEL-1:0] cur_q, cur_d;
    logic                                abs_valid_q, abs_valid_d;
    logic [X-1:0][PIXEL-1:0]             row_bot, row_top, commit_row;
    logic [STEP-1:0][X-1:0][PIXEL-1:0]   rows_bot, rows_top;
    logic                                commit;
    logic [BW-1:0]                       commit_bank;

    assign row_bot  = ref_row_bot;
    assign row_top  = ref_row_top;
    assign rows_bot = ref_rows_bot;
    assign rows_top = ref_rows_top;

    me_cur_loader #(
        .PIXEL (PIXEL),
        .X     (X),
        .Y     (Y),
        .CPC   (CPC),
        .NUM_CB(NUM_CB)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .cur_pix_in (cur_pix_in),
        .cur_valid  (cur_valid),
        .cur_bank   (cur_bank),
        .cur_clr    (cur_clr),
        .cb_loaded  (cb_loaded),
        .cur_busy   (cur_busy),
        .commit     (commit),
        .commit_bank(commit_bank),
        .commit_row (commit_row)
    );

    always_comb begin
        ref_d = ref_q;
        if (ref_shift) begin
            case (ref_mode_e'(ref_mode))
                REF_UP1: begin
                    for (int r = 0; r < Y - 1; r++) ref_d[r] = ref_q[r+1];
                    ref_d[Y-1] = row_bot;
                end
                REF_DN1: begin
                    for (int r = 1; r < Y; r++) ref_d[r] = ref_q[r-1];
                    ref_d[0] = row_top;
                end
                REF_UPS: begin
                    for (int r = 0; r < Y - STEP; r++) ref_d[r] = ref_q[r+STEP];
                    for (int i = 0; i < STEP; i++) ref_d[Y-STEP+i] = rows_bot[i];
                end
                REF_DNS: begin
                    for (int r = STEP; r < Y; r++) ref_d[r] = ref_q[r-STEP];
                    for (int i = 0; i < STEP; i++) ref_d[i] = rows_top[i];
                end
            endcase
        end
    end

    // Committed rows enter at the bottom so the first row of a block ends up on top.
    always_comb begin
        cur_d = cur_q;
        if (commit) begin
            for (int r = 0; r < Y - 1; r++) cur_d[commit_bank][r] = cur_q[commit_bank][r+1];
            cur_d[commit_bank][Y-1] = commit_row;
        end
    end

    always_comb begin
        cur_sel     = cur_q[abs_bank];
        abs_d       = abs_q;
        abs_valid_d = abs_en;
        if (abs_en) begin
            for (int r = 0; r < Y; r++) begin
                for (int c = 0; c < X; c++) begin
                    abs_d[r][c] = (ref_q[r][c] >= cur_sel[r][c]) ?
                                  ref_q[r][c] - cur_sel[r][c] :
                                  cur_sel[r][c] - ref_q[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q       <= '0;
            cur_q       <= '0;
            abs_q       <= '0;
            abs_valid_q <= 1'b0;
        end else begin
            ref_q       <= ref_d;
            cur_q       <= cur_d;
            abs_q       <= abs_d;
            abs_valid_q <= abs_valid_d;
        end
    end

    assign abs_out   = abs_q;
    assign abs_valid = abs_valid_q;

`ifdef ME_ROW_SAD_EN
    logic [Y-1:0][SW-1:0] row_sad_q, row_sad_d;
    logic                 row_sad_valid_q, row_sad_valid_d;

    always_comb begin
        row_sad_d       = row_sad_q;
        row_sad_valid_d = abs_valid_q;
        if (abs_valid_q) begin
            for (int r = 0; r < Y; r++) begin
                row_sad_d[r] = '0;
                for (int c = 0; c < X; c++) row_sad_d[r] = row_sad_d[r] + SW'(abs_q[r][c]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sad_q       <= '0;
            row_sad_valid_q <= 1'b0;
        end else begin
            row_sad_q       <= row_sad_d;
            row_sad_valid_q <= row_sad_valid_d;
        end
    end

    assign row_sad       = row_sad_q;
    assign row_sad_valid = row_sad_valid_q;
`endif

endmodule

// File: tb/tb_me_pe_array_p.sv
// Scoreboard bench for me_pe_array_p on a 4x4 array with two-row steps.
module tb_me_pe_array_p;
    import me_pkg::*;

    localparam int PIXEL  = 8;
    localparam int X      = 4;
    localparam int Y      = 4;
    localparam int STEP   = 2;
    localparam int CPC    = 2;
    localparam int NUM_CB = 4;
    localparam int VW     = X * Y * PIXEL;
    localparam int RW     = X * PIXEL;

    typedef logic [X-1:0][PIXEL-1:0] row_t;
    typedef logic [VW-1:0] vec_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [CPC*PIXEL-1:0]    cur_pix_in;
    logic                    cur_valid, cur_clr, ref_shift, abs_en;
    logic [1:0]              cur_bank, ref_mode, abs_bank;
    logic [NUM_CB-1:0]       cb_loaded;
    logic                    cur_busy, abs_valid;
    logic [RW-1:0]           ref_row_bot, ref_row_top;
    logic [STEP*RW-1:0]      ref_rows_bot, ref_rows_top;
    logic [VW-1:0]           abs_out;
`ifdef ME_ROW_SAD_EN
    logic [Y*(PIXEL+2)-1:0]  row_sad;
    logic                    row_sad_valid;
`endif

    always #5 clk = ~clk;

    me_pe_array_p #(
        .PIXEL(PIXEL), .X(X), .Y(Y), .STEP(STEP), .CPC(CPC), .NUM_CB(NUM_CB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cur_pix_in(cur_pix_in), .cur_valid(cur_valid), .cur_bank(cur_bank), .cur_clr(cur_clr),
        .cb_loaded(cb_loaded), .cur_busy(cur_busy),
        .ref_shift(ref_shift), .ref_mode(ref_mode),
        .ref_row_bot(ref_row_bot), .ref_row_top(ref_row_top),
        .ref_rows_bot(ref_rows_bot), .ref_rows_top(ref_rows_top),
        .abs_en(abs_en), .abs_bank(abs_bank), .abs_out(abs_out), .abs_valid(abs_valid)
`ifdef ME_ROW_SAD_EN
        , .row_sad(row_sad), .row_sad_valid(row_sad_valid)
`endif
    );

    int total = 0;
    int bad   = 0;

    vec_t              exp_q[$];
    vec_t              held = '0;
    row_t              ref_m[$];
    row_t              cur_m[NUM_CB][Y];
    pixel_t            blk[$];
    logic [1:0]        m_bank;
    logic [NUM_CB-1:0] m_loaded;

    task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t modelAbs(input logic [1:0] b);
        vec_t   v;
        pixel_t a, d;
        v = '0;
        for (int r = 0; r < Y; r++) begin
            for (int c = 0; c < X; c++) begin
                a = ref_m[r][c];
                d = cur_m[b][r][c];
                v[(r*X+c)*PIXEL +: PIXEL] = (a > d) ? a - d : d - a;
            end
        end
        return v;
    endfunction

    task automatic resetModel();
        ref_m.delete();
        for (int r = 0; r < Y; r++) ref_m.push_back('0);
        for (int b = 0; b < NUM_CB; b++)
            for (int r = 0; r < Y; r++) cur_m[b][r] = '0;
        blk.delete();
        m_loaded = '0;
        m_bank   = '0;
    endtask

    task automatic clearInputs();
        cur_valid = 1'b0; cur_clr = 1'b0; ref_shift = 1'b0; abs_en = 1'b0;
    endtask

    // Model update from the pre-edge state, then one clock and per-cycle checks.
    task automatic applyStimulus();
        logic ae;
        row_t nr, dummy;
        ae = abs_en;
        if (abs_en) exp_q.push_back(modelAbs(abs_bank));
        if (ref_shift) begin
            case (ref_mode)
                2'd0: begin dummy = ref_m.pop_front(); ref_m.push_back(ref_row_bot); end
                2'd1: begin dummy = ref_m.pop_back(); ref_m.push_front(ref_row_top); end
                2'd2: begin
                    for (int i = 0; i < STEP; i++) dummy = ref_m.pop_front();
                    for (int i = 0; i < STEP; i++) ref_m.push_back(ref_rows_bot[i*RW +: RW]);
                end
                default: begin
                    for (int i = 0; i < STEP; i++) dummy = ref_m.pop_back();
                    for (int i = STEP - 1; i >= 0; i--) ref_m.push_front(ref_rows_top[i*RW +: RW]);
                end
            endcase
        end
        if (cur_clr) begin
            blk.delete();
        end else if (cur_valid) begin
            if (blk.size() == 0) begin
                m_bank = cur_bank;
                m_loaded[m_bank] = 1'b0;
            end
            for (int j = 0; j < CPC; j++) blk.push_back(cur_pix_in[j*PIXEL +: PIXEL]);
            if (blk.size() % X == 0) begin
                for (int c = 0; c < X; c++) nr[c] = blk[blk.size() - X + c];
                for (int r = 0; r < Y - 1; r++) cur_m[m_bank][r] = cur_m[m_bank][r+1];
                cur_m[m_bank][Y-1] = nr;
            end
            if (blk.size() == X * Y) begin
                m_loaded[m_bank] = 1'b1;
                blk.delete();
            end
        end
        @(posedge clk);
        #1;
        checkOutput("abs_valid", abs_valid, ae);
        checkOutput("cb_loaded", cb_loaded, m_loaded);
        checkOutput("cur_busy", cur_busy, blk.size() != 0);
        clearInputs();
    endtask

    task automatic loadBeat(input logic [1:0] bank, input logic [CPC*PIXEL-1:0] pix, input logic clr);
        cur_valid = 1'b1; cur_bank = bank; cur_pix_in = pix; cur_clr = clr;
        applyStimulus();
    endtask

    task automatic absOn(input logic [1:0] bank);
        abs_en = 1'b1; abs_bank = bank;
        applyStimulus();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held = '0;
        end else if (abs_valid) begin
            if (exp_q.size() == 0) checkOutput("abs_unexpected", abs_valid, 1'b0);
            else begin
                held = exp_q.pop_front();
                checkOutput("abs_out", abs_out, held);
            end
        end else begin
            checkOutput("abs_hold", abs_out, held);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t e;
        logic [7:0] sv [4];
        rst_n = 1'b0;
        clearInputs();
        cur_bank = '0; cur_pix_in = '0; ref_mode = '0; abs_bank = '0;
        ref_row_bot = '0; ref_row_top = '0; ref_rows_bot = '0; ref_rows_top = '0;
        resetModel();
        #12 rst_n = 1'b1;
        checkOutput("reset_cb_loaded", cb_loaded, '0);
        checkOutput("reset_cur_busy", cur_busy, '0);
        checkOutput("reset_abs_out", abs_out, '0);
        checkOutput("reset_abs_valid", abs_valid, '0);

        for (int k = 1; k <= 8; k++) loadBeat(2'd1, {8'(2*k), 8'(2*k-1)}, 1'b0);
        checkOutput("bank1_loaded", cb_loaded, 4'b0010);
        absOn(2'd1);
        for (int i = 0; i < X * Y; i++) e[i*PIXEL +: PIXEL] = 8'(i + 1);
        checkOutput("bank1_contents", abs_out, e);

        ref_shift = 1'b1; ref_mode = REF_UP1; ref_row_bot = {4{8'd7}};
        applyStimulus();
        absOn(2'd1);
        checkOutput("up1_row3_abs", abs_out[3*RW +: RW], 32'h09080706);
        checkOutput("up1_row0_abs", abs_out[0 +: RW], 32'h04030201);
        applyStimulus();
        checkOutput("abs_pulse_low", abs_valid, 1'b0);

        for (int k = 1; k <= 4; k++) loadBeat(2'd2, 16'($urandom()), 1'b0);
        loadBeat(2'd2, 16'($urandom()), 1'b1);
        checkOutput("clr_busy", cur_busy, 1'b0);
        checkOutput("clr_loaded", cb_loaded, 4'b0010);
        for (int k = 1; k <= 8; k++) loadBeat(2'd2, 16'($urandom()), 1'b0);
        checkOutput("reload_loaded", cb_loaded, 4'b0110);

        for (int r = 0; r < Y; r++) begin
            ref_shift = 1'b1; ref_mode = REF_UP1; ref_row_bot = {4{8'(r)}};
            applyStimulus();
        end
        ref_shift = 1'b1; ref_mode = REF_UPS; ref_rows_bot = {8{8'd9}};
        applyStimulus();
        absOn(2'd0);
        sv = '{8'd2, 8'd3, 8'd9, 8'd9};
        for (int r = 0; r < Y; r++) checkOutput("upstep_row", abs_out[r*RW +: RW], {4{sv[r]}});
        ref_shift = 1'b1; ref_mode = REF_DNS; ref_rows_top = {8{8'd5}};
        applyStimulus();
        absOn(2'd0);
        sv = '{8'd5, 8'd5, 8'd2, 8'd3};
        for (int r = 0; r < Y; r++) checkOutput("dnstep_row", abs_out[r*RW +: RW], {4{sv[r]}});
        applyStimulus();

        loadBeat(2'd3, 16'h1234, 1'b0);
        cur_valid = 1'b1; cur_bank = 2'd3; ref_shift = 1'b1; ref_mode = REF_DN1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_cb_loaded", cb_loaded, '0);
        checkOutput("async_cur_busy", cur_busy, '0);
        checkOutput("async_abs_out", abs_out, '0);
        checkOutput("async_abs_valid", abs_valid, '0);
        clearInputs();
        resetModel();
        #10 rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            cur_valid    = 1'($urandom_range(0, 1));
            cur_pix_in   = 16'($urandom());
            cur_bank     = 2'($urandom_range(0, 3));
            cur_clr      = ($urandom_range(0, 19) == 0);
            ref_shift    = 1'($urandom_range(0, 1));
            ref_mode     = 2'($urandom_range(0, 3));
            ref_row_bot  = $urandom();
            ref_row_top  = $urandom();
            ref_rows_bot = {$urandom(), $urandom()};
            ref_rows_top = {$urandom(), $urandom()};
            abs_en       = 1'($urandom_range(0, 1));
            abs_bank     = 2'($urandom_range(0, 3));
            applyStimulus();
        end
        repeat (3) applyStimulus();
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/me_pe_array_p.md
ME_PE_ARRAY_P -- requirements
Module: me_pe_array_p

Interface
REQ-001 SHALL have parameters: PIXEL, default 8, pixel bit width; X, default 32, array columns; Y, default 32, array rows; STEP, default 8, multi-row reference shift distance (1 < STEP < Y); CPC, default 2, current pixels per beat (divides X); NUM_CB, default 4, current-block banks (power of 2).
REQ-002 SHALL have ports: clk in 1, clock; rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: cur_pix_in in CPC*PIXEL, current-frame pixels, lowest slice is lowest column; cur_valid in 1, beat qualifier; cur_bank in log2(NUM_CB), target bank; cur_clr in 1, abort the current load.
REQ-004 SHALL have ports: cb_loaded out NUM_CB, per-bank block-complete flags; cur_busy out 1, load in progress.
REQ-005 SHALL have ports: ref_shift in 1, reference shift strobe; ref_mode in 2, 0=up1, 1=down1, 2=upSTEP, 3=downSTEP.
REQ-006 SHALL have ports: ref_row_bot in X*PIXEL, bottom row fed by up1; ref_row_top in X*PIXEL, top row fed by down1.
REQ-007 SHALL have ports: ref_rows_bot in STEP*X*PIXEL, rows fed by upSTEP; ref_rows_top in STEP*X*PIXEL, rows fed by downSTEP; in both, row slice 0 is topmost.
REQ-008 SHALL have ports: abs_en in 1, compute strobe; abs_bank in log2(NUM_CB), bank compared; abs_out out X*Y*PIXEL, registered absolute differences, PE(r,c) at slice r*X+c; abs_valid out 1.

Function
REQ-009 Row 0 SHALL be the top row, and column 0 SHALL be the least-significant slice.
REQ-010 Current load SHALL use a beat counter (0..X/CPC-1) and a row counter (0..Y-1); beat k SHALL write columns k*CPC..k*CPC+CPC-1 of a staging row.
REQ-011 On the final beat of a row, the completed staging row (including that beat) SHALL enter row Y-1 of the bank, and all rows of that bank SHALL shift up by one in the same cycle.
REQ-012 cur_bank SHALL be latched on the first beat of a block and ignored until the block ends; that first beat SHALL clear cb_loaded of the latched bank.
REQ-013 cb_loaded bit SHALL set in the cycle after the Y-th row commits; the counters then SHALL return to 0 and cur_busy SHALL fall.
REQ-014 cur_busy SHALL be 1 from the cycle after the first beat until the block completes.
REQ-015 cur_clr SHALL zero both counters and cur_busy next cycle, leave the bank's cb_loaded at 0, and win over a simultaneous cur_valid.
REQ-016 ref_shift=1 SHALL apply one of four moves per cycle:
- up1: row r<-r+1, row Y-1<-ref_row_bot.
- down1: row r<-r-1, row 0<-ref_row_top.
- upSTEP: row r<-r+STEP, rows Y-STEP..Y-1<-ref_rows_bot.
- downSTEP: row r<-r-STEP, rows 0..STEP-1<-ref_rows_top.
REQ-017 ref_shift=0 SHALL hold the reference array.
REQ-018 abs_en=1 SHALL register |ref(r,c) - cur[abs_bank](r,c)|, an unsigned PIXEL-bit result, into abs_out one cycle later, with abs_valid=1 for exactly that cycle.
REQ-019 abs SHALL use array contents before any same-cycle shift or load.
REQ-020 abs_out SHALL hold its value when abs_en=0.
REQ-021 Loading, reference shifting and abs SHALL operate independently in the same cycle.
REQ-022 abs_bank equal to the loading bank SHALL compare partially loaded data without error.

Reset
REQ-023 rst_n low SHALL asynchronously clear all reference, current and staging registers, counters, latched bank, cb_loaded, cur_busy, abs_out and abs_valid to 0.
REQ-024 Reset mid-load SHALL discard the partial block.

Configuration
REQ-025 With ME_ROW_SAD_EN defined, the block SHALL add output row_sad (Y*(PIXEL+clog2(X)) bits), where row_sad[r] = sum of row r of abs_out, registered one cycle after abs_valid, with row_sad_valid.
REQ-026 Without ME_ROW_SAD_EN, those ports and the adders SHALL be absent, with no other change.

Structure
REQ-027 A shared package me_pkg SHALL hold: the ref_mode encodings (REF_UP1, REF_DN1, REF_UPS, REF_DNS); default PIXEL/X/Y/STEP; and the pixel typedef.
REQ-028 The block SHALL contain one sub-module, me_cur_loader (staging row, counters, bank latch, cb_loaded), with the array, shift and abs logic in the top.

Verification
REQ-029 X=Y=4, CPC=2, bank 1: 8 beats of values 1..16 -> cb_loaded=4'b0010 the cycle after beat 8; rows 0..3 of bank 1 hold 1-4, 5-8, 9-12, 13-16.
REQ-030 Reference all 0, up1 with ref_row_bot=all 7, abs_en with bank 1 the next cycle -> row 3 abs = |7-13..16| = 6,7,8,9; rows 0-2 equal the current values; abs_valid is a one-cycle pulse.
REQ-031 STEP=2, reference rows = row index: upSTEP with ref_rows_bot={9,9} -> rows 2,3,9,9; then downSTEP with ref_rows_top={5,5} -> rows 5,5,2,3.
REQ-032 cur_clr on beat 5 -> cur_busy=0 next cycle and cb_loaded unchanged; a fresh 8-beat load then completes normally.
REQ-033 rst_n pulled low asynchronously mid-shift -> all outputs 0 before the next clk edge.
REQ-034 With ME_ROW_SAD_EN and abs row values 255,255,255,255 -> row_sad=1020 two cycles after abs_en.
